pmem_line_responder: RTL and testbench
======================================

# pmem_line_responder

Synthesizable responder for the 256-bit physical-memory line interface (the far end of `pmem_*`). It accepts one line-wide read or write at a time from the `mp3` core's cacheline/arbiter side, waits a programmable latency, then pulses `pmem_resp` for one cycle. It is used as an on-chip memory stand-in for FPGA bring-up and as a protocol checker for the initiator side.

## Interface
- `LINE_BITS`, 256, line width in bits (fixed by the protocol).
- `IDX_BITS`, 8, line-index width; memory depth is 2^IDX_BITS lines.
- `LATENCY`, 8, cycles from request first visible to `pmem_resp` high; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pmem_read` in 1: read request; held high by the initiator until `pmem_resp`.
- `pmem_write` in 1: write request; held high by the initiator until `pmem_resp`.
- `pmem_addr` in 32: byte address; bits [4:0] ignored.
- `pmem_wdata` in 256: write line; sampled at acceptance.
- `pmem_resp` out 1: one-cycle completion pulse.
- `pmem_rdata` out 256: read line; valid in the `pmem_resp` cycle, held until the next read completes.
- `proto_err` out 1: sticky protocol-violation flag.
- `rd_count` out 16, `wr_count` out 16: saturating counts of completed reads/writes.

## Operation
- FSM states: `IDLE`, `WAIT`, `RESP`.
- `IDLE`: exactly one of read/write high -> accept: latch op, index = `pmem_addr[5 +: IDX_BITS]`, and `wdata`; load `cnt = LATENCY-1`; go to `RESP` if `LATENCY==1`, else `WAIT`. Both high -> set `proto_err`, accept nothing, stay `IDLE`.
- Upper address bits above `5+IDX_BITS` are ignored, so addresses wrap modulo depth.
- `WAIT`: decrement `cnt`; leaving `WAIT` with `cnt==1` -> `RESP`.
- `WAIT`, request dropped before completion, or op/address changed from the latched value: set `proto_err`, abort with no memory write and no resp, return to `IDLE`.
- `RESP`: `pmem_resp=1` for one cycle; unconditional return to `IDLE`.
- Write commit: RAM is written on the edge entering `RESP`. A read issued after that resp returns the new data.
- Read: RAM is read on the edge entering `RESP` and registered into `pmem_rdata`.
- Counters increment on the edge leaving `RESP` and saturate at 0xFFFF.
- RAM contents are not cleared by reset and are undefined until written.

## Timing
- Request first high in cycle 0 -> `pmem_resp` high in cycle `LATENCY`, for exactly one cycle.
- The initiator deasserts the request in cycle `LATENCY+1`. If it is still high in that cycle while in `IDLE`, it is a new request. Back-to-back throughput is one line per `LATENCY+1` cycles.
- Reset values: state `IDLE`, `pmem_resp=0`, `pmem_rdata=0`, `proto_err=0`, counters 0, `cnt=0`.
- `rst` asserted mid-transaction takes effect immediately and asynchronously:
  - pending write is discarded and no resp is issued;
  - the first request after deassertion is accepted normally.
- A request in the same cycle as `RESP` is ignored. The initiator must not hold the request past resp.

## Structure
- `pmem_pkg`: `PMEM_LINE_BITS=256`, `PMEM_OFFSET_BITS=5`, `pmem_state_t` enum {IDLE, WAIT, RESP}, `pmem_op_t` enum {OP_READ, OP_WRITE}.
- Sub-module `pmem_line_ram`: 2^IDX_BITS x LINE_BITS, single port, synchronous read and write, one enable each. No reset.
- The top level holds the FSM, latency counter, latch registers, error and counter logic.

## Test plan
- Reset, `LATENCY=8`: write 0xA5…A5 to 0x0000_0040, then read 0x0000_0040 -> resp in cycle 8 of each op; `rdata=0xA5…A5`; `wr_count=1`, `rd_count=1`.
- Aliasing, `IDX_BITS=8`: write line X to 0x0000_2040, read 0x0000_0040 -> returns X (wrap at 8 KiB).
- `pmem_read` and `pmem_write` both high in `IDLE` -> `proto_err=1`, no resp within 20 cycles, counters unchanged.
- `pmem_write` dropped at cycle 3 of 8 -> `proto_err=1`, no resp; a subsequent read of that line returns the previous contents.
- `rst` pulsed at cycle 5 of a write -> all outputs return to reset values immediately, write not committed; the next read completes in `LATENCY` cycles.
- `LATENCY=1`, back-to-back reads of 0x00 and 0x20 -> resp in cycle 1 and cycle 3; each `rdata` matches its stored line.

Source files
------------

// File: rtl/pmem_pkg.sv
// ----------------------------------------------------------------------------
// pmem_pkg
// Shared definitions for the 256-bit physical-memory line responder:
// line geometry, FSM state encoding and the latched operation type.
// No ports (package).
// ----------------------------------------------------------------------------
package pmem_pkg;

   localparam int PMEM_LINE_BITS   = 256;
   localparam int PMEM_OFFSET_BITS = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } pmem_state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } pmem_op_t;

endpackage : pmem_pkg

// File: rtl/pmem_line_ram.sv
// ----------------------------------------------------------------------------
// pmem_line_ram
// Single-port line RAM, 2^IDX_BITS entries of LINE_BITS bits. Synchronous
// write and synchronous read, each with its own enable. No reset: contents
// and the read register are undefined until written.
//
// Ports:
//   clk_i    clock
//   we_i     write enable (wdata_i stored at idx_i on the rising edge)
//   re_i     read enable  (mem[idx_i] registered into rdata_o)
//   idx_i    line index
//   wdata_i  write line
//   rdata_o  registered read line, held while re_i is low
// ----------------------------------------------------------------------------
module pmem_line_ram
   import pmem_pkg::*;
#(
   parameter int LINE_BITS = PMEM_LINE_BITS,
   parameter int IDX_BITS  = 8
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic                 re_i,
   input  logic [IDX_BITS-1:0]  idx_i,
   input  logic [LINE_BITS-1:0] wdata_i,
   output logic [LINE_BITS-1:0] rdata_o
);

   logic [LINE_BITS-1:0] mem_q [2**IDX_BITS];
   logic [LINE_BITS-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : pmem_line_ram

// File: rtl/pmem_line_responder.sv
// ----------------------------------------------------------------------------
// pmem_line_responder
// Far-end responder for the pmem line interface. Accepts one line read or
// write at a time, waits LATENCY cycles from the first request cycle, then
// pulses pmem_resp for one cycle. Also checks the initiator: conflicting
// read+write, a dropped request, or a request whose op/address changes while
// pending all set the sticky proto_err flag (and abort a pending access).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pmem_read/write     request strobes, held until pmem_resp
//   pmem_addr           byte address (bits [4:0] ignored, wraps mod depth)
//   pmem_wdata          write line, captured at acceptance
//   pmem_resp           one-cycle completion pulse
//   pmem_rdata          read line, valid in the resp cycle and held until the
//                       next read completes (zero after reset)
//   proto_err           sticky protocol-violation flag
//   rd_count, wr_count  saturating counts of completed reads / writes
// ----------------------------------------------------------------------------
module pmem_line_responder
   import pmem_pkg::*;
#(
   parameter int LINE_BITS = PMEM_LINE_BITS,
   parameter int IDX_BITS  = 8,
   parameter int LATENCY   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pmem_read,
   input  logic                 pmem_write,
   input  logic [31:0]          pmem_addr,
   input  logic [LINE_BITS-1:0] pmem_wdata,
   output logic                 pmem_resp,
   output logic [LINE_BITS-1:0] pmem_rdata,
   output logic                 proto_err,
   output logic [15:0]          rd_count,
   output logic [15:0]          wr_count
);

   localparam int          LADDR_W = 32 - PMEM_OFFSET_BITS;
   localparam logic [7:0]  LAT_M1  = 8'(LATENCY - 1);

   pmem_state_t          state_q, state_d;
   pmem_op_t             op_q, op_d;
   logic [LADDR_W-1:0]   laddr_q, laddr_d;
   logic [LINE_BITS-1:0] wdata_q, wdata_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 rvld_q, rvld_d;
   logic [15:0]          rd_cnt_q, rd_cnt_d;
   logic [15:0]          wr_cnt_q, wr_cnt_d;

   logic                 ram_we, ram_re;
   logic [IDX_BITS-1:0]  ram_idx;
   logic [LINE_BITS-1:0] ram_wdata, ram_rdata;

   logic                 req_one;
   pmem_op_t             req_op;
   logic                 req_ok;
   logic                 unused_addr;

   // Byte-offset bits carry no information for a line-wide access.
   assign unused_addr = ^pmem_addr[PMEM_OFFSET_BITS-1:0];

   assign req_one = pmem_read ^ pmem_write;
   assign req_op  = pmem_write ? OP_WRITE : OP_READ;
   // While pending, the initiator must keep presenting exactly the latched
   // op and line address (full line address, not just the wrapped index).
   assign req_ok  = req_one && (req_op == op_q) &&
                    (pmem_addr[31:PMEM_OFFSET_BITS] == laddr_q);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      laddr_d   = laddr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      rvld_d    = rvld_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_idx   = laddr_q[IDX_BITS-1:0];
      ram_wdata = wdata_q;

      case (state_q)
         IDLE: begin
            if (pmem_read && pmem_write) begin
               err_d = 1'b1;
            end else if (req_one) begin
               op_d    = req_op;
               laddr_d = pmem_addr[31:PMEM_OFFSET_BITS];
               wdata_d = pmem_wdata;
               cnt_d   = LAT_M1;
               if (LATENCY == 1) begin
                  // Zero wait cycles: the RAM access happens on this very
                  // edge, so it must use the live request fields.
                  state_d   = RESP;
                  ram_idx   = pmem_addr[PMEM_OFFSET_BITS +: IDX_BITS];
                  ram_wdata = pmem_wdata;
                  ram_we    = pmem_write;
                  ram_re    = pmem_read;
                  if (pmem_read) begin
                     rvld_d = 1'b1;
                  end
               end else begin
                  state_d = WAIT;
               end
            end
         end

         WAIT: begin
            if (!req_ok) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d = RESP;
                  ram_we  = (op_q == OP_WRITE);
                  ram_re  = (op_q == OP_READ);
                  if (op_q == OP_READ) begin
                     rvld_d = 1'b1;
                  end
               end
            end
         end

         RESP: begin
            state_d = IDLE;
            if (op_q == OP_READ) begin
               if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            end else begin
               if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         rvld_q   <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         rvld_q   <= rvld_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   // Request latch: only meaningful while a transaction is pending, so it
   // needs no reset.
   always_ff @(posedge clk) begin
      op_q    <= op_d;
      laddr_q <= laddr_d;
      wdata_q <= wdata_d;
   end

   pmem_line_ram #(
      .LINE_BITS (LINE_BITS),
      .IDX_BITS  (IDX_BITS)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .idx_i   (ram_idx),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   assign pmem_resp  = (state_q == RESP);
   // RAM read register has no reset; gate it so rdata reads zero until the
   // first read completes after reset.
   assign pmem_rdata = rvld_q ? ram_rdata : '0;
   assign proto_err  = err_q;
   assign rd_count   = rd_cnt_q;
   assign wr_count   = wr_cnt_q;

endmodule : pmem_line_responder

// File: tb/tb_pmem_line_responder.sv
module tb_pmem_line_responder;

   logic         clk = 1'b0;
   logic         rst = 1'b1;

   logic         rd8 = 1'b0, wr8 = 1'b0;
   logic [31:0]  addr8 = '0;
   logic [255:0] wd8 = '0;
   logic         resp8, err8;
   logic [255:0] rdata8;
   logic [15:0]  rc8, wc8;

   logic         rd1 = 1'b0, wr1 = 1'b0;
   logic [31:0]  addr1 = '0;
   logic [255:0] wd1 = '0;
   logic         resp1, err1;
   logic [255:0] rdata1;
   logic [15:0]  rc1, wc1;

   int errors = 0;
   int checks = 0;

   localparam logic [255:0] PAT_A5 = {32{8'hA5}};
   localparam logic [255:0] PAT_X  = {16{16'hC33C}};
   localparam logic [255:0] PAT_Y  = {32{8'h5A}};
   localparam logic [255:0] PAT_Z  = {8{32'hDEADBEEF}};
   localparam logic [255:0] PAT_L0 = {4{64'h0123456789ABCDEF}};
   localparam logic [255:0] PAT_L1 = {4{64'hFEDCBA9876543210}};

   always #5 clk = ~clk;

   pmem_line_responder #(.LINE_BITS(256), .IDX_BITS(8), .LATENCY(8)) dut8 (
      .clk(clk), .rst(rst), .pmem_read(rd8), .pmem_write(wr8),
      .pmem_addr(addr8), .pmem_wdata(wd8), .pmem_resp(resp8),
      .pmem_rdata(rdata8), .proto_err(err8), .rd_count(rc8), .wr_count(wc8)
   );

   pmem_line_responder #(.LINE_BITS(256), .IDX_BITS(8), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .pmem_read(rd1), .pmem_write(wr1),
      .pmem_addr(addr1), .pmem_wdata(wd1), .pmem_resp(resp1),
      .pmem_rdata(rdata1), .proto_err(err1), .rd_count(rc1), .wr_count(wc1)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction on the LATENCY=8 instance. lat = cycle of resp relative
   // to the first request cycle (-1 if none within the budget).
   task automatic op8(input logic wr, input logic [31:0] a, input logic [255:0] d,
                      output int lat, output logic [255:0] rd);
      @(posedge clk); #1;
      rd8 = ~wr; wr8 = wr; addr8 = a; wd8 = d;
      lat = -1; rd = '0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (resp8 === 1'b1) begin
            lat = k; rd = rdata8;
            break;
         end
      end
      @(posedge clk); #1;
      rd8 = 1'b0; wr8 = 1'b0;
      @(negedge clk);
      chk("op8_resp_single", {255'd0, resp8}, 256'd0);
   endtask

   task automatic op1(input logic wr, input logic [31:0] a, input logic [255:0] d,
                      output int lat);
      @(posedge clk); #1;
      rd1 = ~wr; wr1 = wr; addr1 = a; wd1 = d;
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (resp1 === 1'b1) begin
            lat = k;
            break;
         end
      end
      @(posedge clk); #1;
      rd1 = 1'b0; wr1 = 1'b0;
   endtask

   task automatic watch8(input int n, output int seen);
      seen = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (resp8 === 1'b1) seen++;
      end
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, seen;
      logic [255:0] rd;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_resp",  {255'd0, resp8}, 256'd0);
      chk("rst_rdata", rdata8, 256'd0);
      chk("rst_err",   {255'd0, err8}, 256'd0);
      chk("rst_rc",    256'(rc8), 256'd0);
      chk("rst_wc",    256'(wc8), 256'd0);

      // Basic write then read, LATENCY=8
      op8(1'b1, 32'h0000_0040, PAT_A5, lat, rd);
      chk("w1_lat", 256'(lat), 256'd8);
      op8(1'b0, 32'h0000_0040, '0, lat, rd);
      chk("r1_lat",  256'(lat), 256'd8);
      chk("r1_data", rd, PAT_A5);
      chk("r1_wc",   256'(wc8), 256'd1);
      chk("r1_rc",   256'(rc8), 256'd1);
      chk("r1_err",  {255'd0, err8}, 256'd0);

      // Aliasing: 0x2040 wraps onto the same line as 0x0040
      op8(1'b1, 32'h0000_2040, PAT_X, lat, rd);
      chk("w2_lat", 256'(lat), 256'd8);
      op8(1'b0, 32'h0000_0040, '0, lat, rd);
      chk("alias_data", rd, PAT_X);
      chk("alias_wc",   256'(wc8), 256'd2);
      chk("alias_rc",   256'(rc8), 256'd2);

      // Read and write both high in IDLE
      @(posedge clk); #1;
      rd8 = 1'b1; wr8 = 1'b1; addr8 = 32'h0000_0080; wd8 = PAT_Y;
      watch8(20, seen);
      chk("both_noresp", 256'(seen), 256'd0);
      chk("both_err",    {255'd0, err8}, 256'd1);
      chk("both_wc",     256'(wc8), 256'd2);
      chk("both_rc",     256'(rc8), 256'd2);
      rd8 = 1'b0; wr8 = 1'b0;

      pulse_rst();
      @(negedge clk);
      chk("rst2_err", {255'd0, err8}, 256'd0);

      // Write dropped in cycle 3 of 8
      @(posedge clk); #1;
      wr8 = 1'b1; addr8 = 32'h0000_0040; wd8 = PAT_Y;
      repeat (3) @(posedge clk);
      #1;
      wr8 = 1'b0;
      watch8(20, seen);
      chk("drop_noresp", 256'(seen), 256'd0);
      chk("drop_err",    {255'd0, err8}, 256'd1);
      chk("drop_wc",     256'(wc8), 256'd0);
      op8(1'b0, 32'h0000_0040, '0, lat, rd);
      chk("drop_rd_lat",  256'(lat), 256'd8);
      chk("drop_rd_data", rd, PAT_X);

      // Reset asserted in cycle 5 of a write
      @(posedge clk); #1;
      wr8 = 1'b1; addr8 = 32'h0000_0040; wd8 = PAT_Z;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("midrst_pre_resp", {255'd0, resp8}, 256'd0);
      rst = 1'b1;
      #1;
      chk("midrst_resp",  {255'd0, resp8}, 256'd0);
      chk("midrst_rdata", rdata8, 256'd0);
      chk("midrst_err",   {255'd0, err8}, 256'd0);
      chk("midrst_rc",    256'(rc8), 256'd0);
      chk("midrst_wc",    256'(wc8), 256'd0);
      wr8 = 1'b0;
      #2;
      rst = 1'b0;
      op8(1'b0, 32'h0000_0040, '0, lat, rd);
      chk("midrst_rd_lat",  256'(lat), 256'd8);
      chk("midrst_rd_data", rd, PAT_X);
      chk("midrst_rd_wc",   256'(wc8), 256'd0);
      chk("midrst_rd_rc",   256'(rc8), 256'd1);

      // LATENCY=1 instance: fill two lines, then back-to-back reads
      op1(1'b1, 32'h0000_0000, PAT_L0, lat);
      chk("l1_w0_lat", 256'(lat), 256'd1);
      op1(1'b1, 32'h0000_0020, PAT_L1, lat);
      chk("l1_w1_lat", 256'(lat), 256'd1);
      @(negedge clk);
      chk("l1_wc", 256'(wc1), 256'd2);

      @(posedge clk); #1;
      rd1 = 1'b1; addr1 = 32'h0000_0000;
      @(negedge clk);
      chk("b2b_c0_resp", {255'd0, resp1}, 256'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_c1_resp",  {255'd0, resp1}, 256'd1);
      chk("b2b_c1_rdata", rdata1, PAT_L0);
      @(posedge clk); #1;
      addr1 = 32'h0000_0020;
      @(negedge clk);
      chk("b2b_c2_resp", {255'd0, resp1}, 256'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_c3_resp",  {255'd0, resp1}, 256'd1);
      chk("b2b_c3_rdata", rdata1, PAT_L1);
      @(posedge clk); #1;
      rd1 = 1'b0;
      @(negedge clk);
      chk("b2b_rc",  256'(rc1), 256'd2);
      chk("b2b_err", {255'd0, err1}, 256'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pmem_line_responder
